// File: rtl/proc_mem_pkg.sv
// rtl/proc_mem_pkg.sv - shared types for the processor/memory arbiter
// Purpose: request-type codes, owner and state enums used by the arbiter
//   and its round-robin helper.
// Ports: none (package).
package proc_mem_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic {
    OWN_IMEM,
    OWN_DMEM
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/proc_mem_arbiter_if.sv
// rtl/proc_mem_arbiter_if.sv - bundle of fetch, data and memory handshakes
// Purpose: groups the imem/dmem request-response ports and the single memory
//   port into one bundle.
// Modports:
//   master - arbiter view: drives req_rdy/resp toward the processor and
//            memreq_*/memresp_rdy toward memory.
//   slave  - environment view (processor + memory): the mirror image.
interface proc_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              imemreq_val;
  logic              imemreq_rdy;
  logic [ADDR_W-1:0] imemreq_addr;
  logic              imemresp_val;
  logic [DATA_W-1:0] imemresp_data;

  logic              dmemreq_val;
  logic              dmemreq_rdy;
  logic              dmemreq_type;
  logic [ADDR_W-1:0] dmemreq_addr;
  logic [DATA_W-1:0] dmemreq_wdata;
  logic              dmemresp_val;
  logic [DATA_W-1:0] dmemresp_data;

  logic              memreq_val;
  logic              memreq_rdy;
  logic              memreq_type;
  logic [ADDR_W-1:0] memreq_addr;
  logic [DATA_W-1:0] memreq_wdata;
  logic              memresp_val;
  logic              memresp_rdy;
  logic [DATA_W-1:0] memresp_data;

  modport master (
    input  imemreq_val, imemreq_addr,
    output imemreq_rdy, imemresp_val, imemresp_data,
    input  dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    output dmemreq_rdy, dmemresp_val, dmemresp_data,
    output memreq_val, memreq_type, memreq_addr, memreq_wdata, memresp_rdy,
    input  memreq_rdy, memresp_val, memresp_data
  );

  modport slave (
    output imemreq_val, imemreq_addr,
    input  imemreq_rdy, imemresp_val, imemresp_data,
    output dmemreq_val, dmemreq_type, dmemreq_addr, dmemreq_wdata,
    input  dmemreq_rdy, dmemresp_val, dmemresp_data,
    input  memreq_val, memreq_type, memreq_addr, memreq_wdata, memresp_rdy,
    output memreq_rdy, memresp_val, memresp_data
  );

endinterface

// File: rtl/proc_mem_arbiter_rr_arb2.sv
// rtl/proc_mem_arbiter_rr_arb2.sv - combinational 2-way round-robin grant
// Purpose: picks imem or dmem; on a tie the one that did not win last time.
// Ports:
//   ival, dval  in   request valids
//   last_grant  in   winner of the previous fired request
//   grant       out  selected requester (imem when neither is valid)
module proc_mem_rr_arb2
  import proc_mem_pkg::*;
(
  input  logic   ival,
  input  logic   dval,
  input  owner_e last_grant,
  output owner_e grant
);

  always_comb begin
    grant = OWN_IMEM;
    if (ival && dval) begin
      grant = (last_grant == OWN_IMEM) ? OWN_DMEM : OWN_IMEM;
    end else if (dval) begin
      grant = OWN_DMEM;
    end
  end

endmodule

// File: rtl/proc_mem_arbiter.sv
// rtl/proc_mem_arbiter.sv - shares one memory port between imem and dmem
// Purpose: round-robin arbitration with the grant locked until memory
//   accepts, one outstanding transaction, response routed to its owner and a
//   sticky timeout flag for a memory that never answers.
// Parameters: TIMEOUT - WAIT cycles without a response before err (>=2).
// Ports:
//   clk  in   clock
//   rst  in   asynchronous active-low reset
//   bus  mst  fetch, data and memory handshakes (proc_mem_arbiter_if.master)
//   err  out  sticky timeout flag
module proc_mem_arbiter
  import proc_mem_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  proc_mem_arbiter_if.master        bus,
  output logic                      err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_d;

  owner_e           arb_grant;
  owner_e           sel;
  logic             sel_val;
  logic             fire;
  logic             resp_fire;

  proc_mem_rr_arb2 u_arb (
    .ival       (bus.imemreq_val),
    .dval       (bus.dmemreq_val),
    .last_grant (last_q),
    .grant      (arb_grant)
  );

  // Only IDLE arbitrates; afterwards the grant stays frozen on the owner.
  assign sel     = (state_q == ST_IDLE) ? arb_grant : owner_q;
  assign sel_val = (sel == OWN_DMEM) ? bus.dmemreq_val : bus.imemreq_val;

  // rst gating keeps every handshake output low while reset is asserted,
  // even though the request path is purely combinational.
  assign bus.memreq_val   = rst && (state_q != ST_WAIT) && sel_val;
  assign bus.memreq_type  = (sel == OWN_DMEM) ? bus.dmemreq_type : MEM_READ;
  assign bus.memreq_addr  = (sel == OWN_DMEM) ? bus.dmemreq_addr : bus.imemreq_addr;
  assign bus.memreq_wdata = (sel == OWN_DMEM) ? bus.dmemreq_wdata : '0;

  assign fire            = bus.memreq_val && bus.memreq_rdy;
  assign bus.imemreq_rdy = fire && (sel == OWN_IMEM);
  assign bus.dmemreq_rdy = fire && (sel == OWN_DMEM);

  // Responses are only consumed in WAIT; anything earlier is left on the bus.
  assign bus.memresp_rdy   = rst && (state_q == ST_WAIT);
  assign resp_fire         = bus.memresp_rdy && bus.memresp_val;
  assign bus.imemresp_val  = resp_fire && (owner_q == OWN_IMEM);
  assign bus.dmemresp_val  = resp_fire && (owner_q == OWN_DMEM);
  assign bus.imemresp_data = bus.memresp_data;
  assign bus.dmemresp_data = bus.memresp_data;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = '0;
    err_d   = err;
    case (state_q)
      ST_IDLE: begin
        if (fire) begin
          state_d = ST_WAIT;
          owner_d = sel;
          last_d  = sel;
        end else if (sel_val) begin
          state_d = ST_REQ;
          owner_d = sel;
        end
      end
      ST_REQ: begin
        if (fire) begin
          state_d = ST_WAIT;
          last_d  = owner_q;
        end
      end
      ST_WAIT: begin
        if (bus.memresp_val) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
          // err rises on the same edge the counter reaches TIMEOUT.
          if (cnt_q >= CNT_W'(TIMEOUT - 1)) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IMEM;
      last_q  <= OWN_IMEM;
      cnt_q   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// tb/tb_proc_mem_arbiter.sv - randomized bench for proc_mem_arbiter
module tb_proc_mem_arbiter;

  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic err;

  proc_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  proc_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who holds the port (-1 = nobody), whether memory has
  // taken that request, who won last, WAIT cycles elapsed and sticky err.
  int   m_owner  = -1;
  logic m_acc    = 1'b0;
  int   m_last   = 0;
  int   m_waited = 0;
  int   m_lat    = 0;
  logic m_err    = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_idle(input string tag);
    check({tag, "_memreq_val"},   bus.memreq_val,   1'b0);
    check({tag, "_imemreq_rdy"},  bus.imemreq_rdy,  1'b0);
    check({tag, "_dmemreq_rdy"},  bus.dmemreq_rdy,  1'b0);
    check({tag, "_memresp_rdy"},  bus.memresp_rdy,  1'b0);
    check({tag, "_imemresp_val"}, bus.imemresp_val, 1'b0);
    check({tag, "_dmemresp_val"}, bus.dmemresp_val, 1'b0);
    check({tag, "_err"},          err,              1'b0);
  endtask

  // Each cycle starts at posedge+1: drive, check at negedge, advance model.
  task automatic run_cycles(input int n, input int lat_lo, input int lat_hi);
    for (int c = 0; c < n; c++) begin
      int          grant;
      logic        iv, dv, waiting, mv, exp_val, exp_fire, drop_i, drop_d;
      logic [31:0] rdata;
      drop_i = 1'b0;
      drop_d = 1'b0;
      if (!bus.imemreq_val && $urandom_range(0, 2) != 0) begin
        bus.imemreq_val  = 1'b1;
        bus.imemreq_addr = $urandom;
      end
      if (!bus.dmemreq_val && $urandom_range(0, 2) != 0) begin
        bus.dmemreq_val   = 1'b1;
        bus.dmemreq_type  = 1'($urandom_range(0, 1));
        bus.dmemreq_addr  = $urandom;
        bus.dmemreq_wdata = $urandom;
      end
      bus.memreq_rdy = ($urandom_range(0, 1) == 1);
      waiting = (m_owner >= 0) && m_acc;
      if (waiting) begin
        mv = (m_lat == 1);
        m_lat--;
      end else begin
        mv = ($urandom_range(0, 7) == 0);
      end
      rdata = $urandom;
      bus.memresp_val  = mv;
      bus.memresp_data = rdata;
      iv = bus.imemreq_val;
      dv = bus.dmemreq_val;
      #4;
      if (m_owner >= 0)      grant = m_owner;
      else if (iv && dv)     grant = 1 - m_last;
      else                   grant = dv ? 1 : 0;
      exp_val  = !waiting && ((grant == 1) ? dv : iv);
      exp_fire = exp_val && bus.memreq_rdy;
      check("memreq_val", bus.memreq_val, exp_val);
      if (exp_val) begin
        check("memreq_addr", bus.memreq_addr, (grant == 1) ? bus.dmemreq_addr : bus.imemreq_addr);
        check("memreq_type", bus.memreq_type, (grant == 1) ? bus.dmemreq_type : 1'b0);
        if (grant == 1) check("memreq_wdata", bus.memreq_wdata, bus.dmemreq_wdata);
      end
      check("imemreq_rdy", bus.imemreq_rdy, exp_fire && grant == 0);
      check("dmemreq_rdy", bus.dmemreq_rdy, exp_fire && grant == 1);
      check("memresp_rdy", bus.memresp_rdy, waiting);
      check("imemresp_val", bus.imemresp_val, waiting && mv && m_owner == 0);
      check("dmemresp_val", bus.dmemresp_val, waiting && mv && m_owner == 1);
      if (waiting && mv) begin
        if (m_owner == 1) check("dmemresp_data", bus.dmemresp_data, rdata);
        else              check("imemresp_data", bus.imemresp_data, rdata);
      end
      check("err", err, m_err);
      if (waiting) begin
        if (mv) begin
          m_owner  = -1;
          m_acc    = 1'b0;
          m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited >= TIMEOUT) m_err = 1'b1;
        end
      end else if (exp_fire) begin
        m_owner  = grant;
        m_acc    = 1'b1;
        m_last   = grant;
        m_waited = 0;
        m_lat    = $urandom_range(lat_lo, lat_hi);
        if (grant == 1) drop_d = 1'b1;
        else            drop_i = 1'b1;
      end else if (m_owner < 0 && exp_val) begin
        m_owner = grant;
      end
      @(posedge clk);
      #1;
      if (drop_i) bus.imemreq_val = 1'b0;
      if (drop_d) bus.dmemreq_val = 1'b0;
    end
  endtask

  initial begin
    bus.imemreq_val   = 1'b1;
    bus.imemreq_addr  = 32'h100;
    bus.dmemreq_val   = 1'b1;
    bus.dmemreq_type  = 1'b1;
    bus.dmemreq_addr  = 32'h200;
    bus.dmemreq_wdata = 32'h1234;
    bus.memreq_rdy    = 1'b1;
    bus.memresp_val   = 1'b1;
    bus.memresp_data  = 32'hCAFE;

    // Outputs held quiet in reset even with every input asserted.
    @(posedge clk);
    #1;
    check_all_idle("reset");
    bus.memresp_val = 1'b0;
    rst = 1'b1;

    // Both valid out of reset: model expects dmem to win the first tie.
    run_cycles(400, 1, 4);
    // Response on the last WAIT cycle before the limit: err must stay low.
    run_cycles(80, TIMEOUT, TIMEOUT);
    // One cycle longer: err sets and the late response still routes.
    run_cycles(60, TIMEOUT + 1, TIMEOUT + 2);
    check("err_sticky", err, 1'b1);
    run_cycles(150, 1, 4);

    // Async reset while a transaction is outstanding.
    for (int k = 0; k < 200 && !(m_owner >= 0 && m_acc); k++) run_cycles(1, 20, 20);
    check("reach_wait", (m_owner >= 0 && m_acc), 1'b1);
    if (!bus.imemreq_val) begin
      bus.imemreq_val  = 1'b1;
      bus.imemreq_addr = $urandom;
    end
    if (!bus.dmemreq_val) begin
      bus.dmemreq_val  = 1'b1;
      bus.dmemreq_addr = $urandom;
    end
    bus.memreq_rdy  = 1'b1;
    bus.memresp_val = 1'b1;
    rst = 1'b0;
    #2;
    check_all_idle("async_rst");
    @(posedge clk);
    #1;
    check_all_idle("rst_hold");
    m_owner  = -1;
    m_acc    = 1'b0;
    m_last   = 0;
    m_waited = 0;
    m_err    = 1'b0;
    bus.memresp_val = 1'b0;
    rst = 1'b1;
    run_cycles(300, 1, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
